// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the 4-point inverse combining stage.
//   W        : sample / coefficient width (two's complement)
//   state_t  : frame-level control states (COLLECT -> COMPUTE -> EMIT)
//   idx_t    : 2-bit position within a 4-element frame
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int W = 12;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/inv_butterfly2.sv
// -----------------------------------------------------------------------------
// inv_butterfly2
// Combinational 2-point inverse butterfly.
//   a, b       : in  W-bit signed operands
//   sum_half   : out floor((a + b) / 2), truncated to W bits
//   diff_half  : out floor((a - b) / 2), truncated to W bits
// A one-bit-wider intermediate keeps the sum/difference exact before the
// arithmetic shift, so the halving never loses the carry.
// -----------------------------------------------------------------------------
module inv_butterfly2 #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_half,
    output logic signed [W-1:0] diff_half
);

    logic signed [W:0] sum_w;
    logic signed [W:0] diff_w;

    assign sum_w  = {a[W-1], a} + {b[W-1], b};
    assign diff_w = {a[W-1], a} - {b[W-1], b};

    // >>> on a signed operand is a floor divide by two
    assign sum_half  = W'(sum_w >>> 1);
    assign diff_half = W'(diff_w >>> 1);

endmodule

// File: rtl/icf_4_stream.sv
// -----------------------------------------------------------------------------
// icf_4_stream
// Inverse 4-point combining stage: collects one frame {X0,X1,X2,X3} from a
// valid/ready input stream, reconstructs {n0,n1,n2,n3} in a single compute
// cycle and emits them in index order on a valid/ready output stream.
//   CLK, RESET          : clock, synchronous active-high reset
//   IN_DATA/VALID/LAST  : coefficient stream in, LAST marks X3
//   IN_READY            : high only while collecting (and not in reset)
//   OUT_DATA/INDEX/LAST : reconstructed sample, its index, LAST with n3
//   OUT_VALID/OUT_READY : output handshake; data holds while stalled
//   FRAME_ERR           : sticky, set when LAST and position disagree
//   FRAME_CNT           : frames fully emitted, wraps
// -----------------------------------------------------------------------------
module icf_4_stream
    import dsp_pkg::*;
#(
    parameter int W   = dsp_pkg::W,
    parameter int FCW = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic signed [W-1:0] IN_DATA,
    input  logic                IN_VALID,
    input  logic                IN_LAST,
    output logic                IN_READY,
    output logic signed [W-1:0] OUT_DATA,
    output logic [1:0]          OUT_INDEX,
    output logic                OUT_VALID,
    output logic                OUT_LAST,
    input  logic                OUT_READY,
    output logic                FRAME_ERR,
    output logic [FCW-1:0]      FRAME_CNT
);

    state_t              state_q, state_d;
    idx_t                idx_q, idx_d;
    idx_t                out_idx_q, out_idx_d;
    logic signed [W-1:0] coef_q [4];
    logic signed [W-1:0] coef_d [4];
    logic signed [W-1:0] samp_q [4];
    logic signed [W-1:0] samp_d [4];
    logic signed [W-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                frame_err_q, frame_err_d;
    logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;

    logic signed [W-1:0] n0, n1, n2, n3;
    logic                in_fire, out_fire;

    // X0/X2 pair yields n0/n2, X1/X3 pair yields n1/n3
    inv_butterfly2 #(.W(W)) u_bf_even (
        .a         (coef_q[0]),
        .b         (coef_q[2]),
        .sum_half  (n0),
        .diff_half (n2)
    );

    inv_butterfly2 #(.W(W)) u_bf_odd (
        .a         (coef_q[1]),
        .b         (coef_q[3]),
        .sum_half  (n1),
        .diff_half (n3)
    );

    assign IN_READY = ~RESET & (state_q == COLLECT);
    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = out_valid_q & OUT_READY;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        coef_d      = coef_q;
        samp_d      = samp_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    coef_d[idx_q] = IN_DATA;
                    if (IN_LAST) begin
                        idx_d = '0;
                        if (idx_q == 2'd3) begin
                            state_d = COMPUTE;
                        end else begin
                            // short frame: drop what was gathered
                            frame_err_d = 1'b1;
                        end
                    end else if (idx_q == 2'd3) begin
                        // fourth coefficient without LAST: frame is misaligned
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            COMPUTE: begin
                samp_d[0]   = n0;
                samp_d[1]   = n1;
                samp_d[2]   = n2;
                samp_d[3]   = n3;
                out_data_d  = n0;
                out_idx_d   = '0;
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                state_d     = EMIT;
            end

            EMIT: begin
                if (out_fire) begin
                    if (out_idx_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_idx_d   = '0;
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                        state_d     = COLLECT;
                    end else begin
                        out_idx_d  = out_idx_q + 2'd1;
                        out_data_d = samp_q[out_idx_d];
                        out_last_d = (out_idx_d == 2'd3);
                    end
                end
            end

            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Coefficient and sample storage carries no reset; control gates its use
    always_ff @(posedge CLK) begin
        coef_q <= coef_d;
        samp_q <= samp_d;
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_INDEX = out_idx_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;
    assign FRAME_ERR = frame_err_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_icf_4_stream.sv
// -----------------------------------------------------------------------------
// tb_icf_4_stream
// Directed and randomized frames for icf_4_stream. Expected samples come from
// floor((a +/- b) / 2) computed with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_icf_4_stream;

    logic               clk;
    logic               rst;
    logic signed [11:0] in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic signed [11:0] out_data;
    logic [1:0]         out_index;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic               frame_err;
    logic [15:0]        frame_cnt;

    int checks;
    int errors;
    int exp_cnt;

    logic signed [11:0] tx [4];
    int                 ex [4];

    icf_4_stream #(.W(12), .FCW(16)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_LAST   (in_last),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_INDEX (out_index),
        .OUT_VALID (out_valid),
        .OUT_LAST  (out_last),
        .OUT_READY (out_ready),
        .FRAME_ERR (frame_err),
        .FRAME_CNT (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // floor(s / 2) without relying on shift semantics
    function automatic int half(input int s);
        if (s >= 0) return s / 2;
        return -((1 - s) / 2);
    endfunction

    function automatic void model_frame();
        int a0, a1, a2, a3;
        a0 = tx[0]; a1 = tx[1]; a2 = tx[2]; a3 = tx[3];
        ex[0] = half(a0 + a2);
        ex[1] = half(a1 + a3);
        ex[2] = half(a0 - a2);
        ex[3] = half(a1 - a3);
    endfunction

    // Offer tx[0..n-1]; LAST on position last_at (-1 for none).
    // Returns at the falling edge just after the final transfer.
    task automatic send(input int n, input int last_at);
        int cyc;
        for (int i = 0; i < n; i++) begin
            in_data  = tx[i];
            in_valid = 1'b1;
            in_last  = (i == last_at);
            cyc = 0;
            while (!in_ready && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("in_ready_wait", int'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Consume up to stop_after samples; pat bit p is OUT_READY in cycle p
    // (1 beyond bit 15). Must be called right after send() completes a frame.
    task automatic recv(input int stop_after, input logic [15:0] pat);
        int lat, k, p, cyc;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("first_valid_latency", lat, 2);
        k = 0; p = 0; cyc = 0;
        while (k < stop_after && cyc < 200) begin
            out_ready = (p < 16) ? pat[p] : 1'b1;
            in_valid  = 1'b1;
            in_data   = 12'($urandom);
            chk("out_valid", int'(out_valid), 1);
            chk("out_data", int'(out_data), ex[k]);
            chk("out_index", int'(out_index), k);
            chk("out_last", int'(out_last), (k == 3) ? 1 : 0);
            chk("in_ready_emit", int'(in_ready), 0);
            if (out_ready) k++;
            @(negedge clk);
            p++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("samples_received", k, stop_after);
        if (stop_after == 4) begin
            exp_cnt++;
            chk("valid_after_frame", int'(out_valid), 0);
            chk("frame_cnt", int'(frame_cnt), exp_cnt);
            chk("in_ready_after", int'(in_ready), 1);
        end
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        tx[0] = 12'(a); tx[1] = 12'(b); tx[2] = 12'(c); tx[3] = 12'(d);
    endtask

    task automatic set_ex(input int a, input int b, input int c, input int d);
        ex[0] = a; ex[1] = b; ex[2] = c; ex[3] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("collect_after_rst", int'(in_ready), 1);

        // Basic frame
        load(130, -43, 70, -57);
        set_ex(100, -50, 30, 7);
        send(4, 3);
        recv(4, 16'hFFFF);

        // Floor rounding on odd sums/differences
        load(5, -5, 2, 2);
        set_ex(3, -2, 1, -4);
        send(4, 3);
        recv(4, 16'hFFFF);

        // Backpressure 1,0,0,1,0,1,1
        load(130, -43, 70, -57);
        set_ex(100, -50, 30, 7);
        send(4, 3);
        recv(4, 16'hFFE9);

        // Randomized frames with random backpressure
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 4; i++) tx[i] = 12'($urandom);
            model_frame();
            send(4, 3);
            recv(4, 16'($urandom));
        end

        // Framing error: LAST on the second coefficient
        load(11, 22, 33, 44);
        send(2, 1);
        chk("err_short_flag", int'(frame_err), 1);
        for (int i = 0; i < 3; i++) begin
            chk("err_short_no_out", int'(out_valid), 0);
            chk("err_short_ready", int'(in_ready), 1);
            @(negedge clk);
        end
        load(130, -43, 70, -57);
        set_ex(100, -50, 30, 7);
        send(4, 3);
        recv(4, 16'hFFFF);
        chk("err_sticky", int'(frame_err), 1);

        // Framing error: four coefficients without LAST
        do_reset();
        chk("err_cleared", int'(frame_err), 0);
        chk("cnt_cleared", int'(frame_cnt), 0);
        load(1, 2, 3, 4);
        send(4, -1);
        chk("err_nolast_flag", int'(frame_err), 1);
        repeat (2) begin
            @(negedge clk);
            chk("err_nolast_no_out", int'(out_valid), 0);
        end
        load(130, -43, 70, -57);
        set_ex(100, -50, 30, 7);
        send(4, 3);
        recv(4, 16'hFFFF);

        // Reset mid-EMIT after n1 accepted
        send(4, 3);
        recv(2, 16'hFFFF);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_index", int'(out_index), 0);
        chk("midrst_out_last", int'(out_last), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("midrst_collect", int'(in_ready), 1);
        chk("midrst_no_beat", int'(out_valid), 0);
        load(5, -5, 2, 2);
        set_ex(3, -2, 1, -4);
        send(4, 3);
        recv(4, 16'hFFFF);

        // Overflow boundaries
        load(2047, 0, 2047, 0);
        set_ex(2047, 0, 0, 0);
        send(4, 3);
        recv(4, 16'hFFFF);
        load(-2048, 2047, -2048, -2048);
        set_ex(-2048, -1, 0, 2047);
        send(4, 3);
        recv(4, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
